// File: rtl/rej_ntt_poly.sv
// -----------------------------------------------------------------------------
// rej_ntt_poly
//
// Rejection sampler for one ExpandA polynomial.  Consumes 64-bit SHAKE128
// squeeze words, slices them into 3-byte little-endian chunks, masks each chunk
// to 23 bits and writes every candidate below Q to the polynomial memory until
// N_COEF coefficients have been produced.
//
// Parameters
//   Q          rejection bound (candidate accepted iff candidate < Q)
//   N_COEF     coefficients per polynomial (<= 256)
//   BLK_WORDS  64-bit words per SHAKE128 squeeze block
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   start        one-cycle pulse, starts sampling (honoured only when idle)
//   in_data      squeeze word, byte 0 = bits [7:0]
//   in_valid     in_data valid
//   in_ready     word accepted this cycle when in_valid & in_ready
//   squeeze_req  one-cycle pulse requesting the next squeeze block
//   coef_we      coefficient write strobe
//   coef_addr    coefficient index
//   coef_data    accepted coefficient
//   busy         high from start until done
//   done         one-cycle pulse after the last coefficient write
//   rej_count    (REJ_NTT_POLY_STATS_EN only) saturating count of rejected
//                candidates since the last start
//
// Build option: define REJ_NTT_POLY_STATS_EN to add the rej_count output.
// -----------------------------------------------------------------------------
module rej_ntt_poly #(
    parameter int unsigned Q         = 8380417,
    parameter int unsigned N_COEF    = 256,
    parameter int unsigned BLK_WORDS = 21
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        squeeze_req,
    output logic        coef_we,
    output logic [7:0]  coef_addr,
    output logic [22:0] coef_data,
    output logic        busy,
    output logic        done
`ifdef REJ_NTT_POLY_STATS_EN
   ,output logic [15:0] rej_count
`endif
);

    localparam int unsigned WW      = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
    localparam logic [23:0] Q_V     = 24'(Q);
    localparam logic [8:0]  LAST_IX = 9'(N_COEF - 1);
    localparam logic [WW-1:0] LAST_W = WW'(BLK_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t          state_q, state_d;

    logic [87:0]     buf_q, buf_d;
    logic [3:0]      fill_q, fill_d;
    logic [8:0]      cnt_q, cnt_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;
    logic            coef_we_q, coef_we_d;
    logic [7:0]      coef_addr_q, coef_addr_d;
    logic [22:0]     coef_data_q, coef_data_d;

    logic            run;
    logic            accept;
    logic            extract;
    logic [22:0]     cand;
    logic            cand_ok;
    logic            last;
    logic            wrap;
    logic            start_go;
    logic [87:0]     shifted;
    logic [3:0]      base;

    // ---------------------------------------------------------------------
    // Handshake and chunk decode
    // ---------------------------------------------------------------------
    assign run      = (state_q == S_RUN);
    assign start_go = (state_q == S_IDLE) && start;
    // Accepting only at fill <= 3 keeps fill <= 10 bytes, inside the 11-byte buffer.
    assign in_ready = run && (fill_q <= 4'd3);
    assign accept   = in_valid && in_ready;
    assign extract  = run && (fill_q >= 4'd3);
    assign cand     = {buf_q[22:16], buf_q[15:0]};
    assign cand_ok  = ({1'b0, cand} < Q_V);
    // The final accepted chunk is known at extraction, so the state moves to
    // FLUSH on the same edge that registers the last write.
    assign last     = extract && cand_ok && (cnt_q == LAST_IX);
    assign wrap     = accept && (wcnt_q == LAST_W);
    assign squeeze_req = wrap && !last;

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                busy    = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Byte buffer, counters and registered coefficient write
    // ---------------------------------------------------------------------
    always_comb begin
        shifted     = extract ? (buf_q >> 24) : buf_q;
        base        = extract ? (fill_q - 4'd3) : fill_q;
        buf_d       = shifted;
        fill_d      = base;
        cnt_d       = cnt_q;
        wcnt_d      = wcnt_q;
        coef_we_d   = 1'b0;
        coef_addr_d = coef_addr_q;
        coef_data_d = coef_data_q;

        // New word lands directly above the bytes left after this cycle's extraction.
        if (accept) begin
            buf_d  = shifted | ({24'd0, in_data} << {base, 3'b000});
            fill_d = base + 4'd8;
            wcnt_d = wrap ? '0 : wcnt_q + WW'(1);
        end

        if (extract && cand_ok) begin
            coef_we_d   = 1'b1;
            coef_addr_d = cnt_q[7:0];
            coef_data_d = cand;
            cnt_d       = cnt_q + 9'd1;
        end

        // Bytes left over after the last coefficient are dropped.
        if (last) begin
            buf_d  = '0;
            fill_d = '0;
        end

        if (start_go) begin
            buf_d  = '0;
            fill_d = '0;
            cnt_d  = '0;
            wcnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q       <= '0;
            fill_q      <= '0;
            cnt_q       <= '0;
            wcnt_q      <= '0;
            coef_we_q   <= 1'b0;
            coef_addr_q <= '0;
            coef_data_q <= '0;
        end else begin
            buf_q       <= buf_d;
            fill_q      <= fill_d;
            cnt_q       <= cnt_d;
            wcnt_q      <= wcnt_d;
            coef_we_q   <= coef_we_d;
            coef_addr_q <= coef_addr_d;
            coef_data_q <= coef_data_d;
        end
    end

    assign coef_we   = coef_we_q;
    assign coef_addr = coef_addr_q;
    assign coef_data = coef_data_q;

`ifdef REJ_NTT_POLY_STATS_EN
    // ---------------------------------------------------------------------
    // Rejection statistics
    // ---------------------------------------------------------------------
    logic [15:0] rej_q, rej_d;

    always_comb begin
        rej_d = rej_q;
        if (start_go) begin
            rej_d = '0;
        end else if (extract && !cand_ok && (rej_q != '1)) begin
            rej_d = rej_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rej_q <= '0;
        end else begin
            rej_q <= rej_d;
        end
    end

    assign rej_count = rej_q;
`endif

endmodule

// File: doc/rej_ntt_poly.md
REJ_NTT_POLY -- requirements
Module: rej_ntt_poly

Interface
REQ-001 Parameter Q, default 8380417, rejection bound; a candidate is accepted iff it is below Q.
REQ-002 Parameter N_COEF, default 256, number of coefficients per polynomial.
REQ-003 Parameter BLK_WORDS, default 21, 64-bit words per SHAKE128 squeeze block (168 bytes).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle pulse that begins sampling one polynomial.
REQ-007 in_data  input  64  squeeze word from the SHAKE128 core; byte 0 = bits [7:0].
REQ-008 in_valid  input  1  in_data is valid.
REQ-009 in_ready  output  1  block accepts in_data this cycle; transfer = in_valid & in_ready.
REQ-010 squeeze_req  output  1  one-cycle pulse requesting the next 168-byte squeeze block.
REQ-011 coef_we  output  1  coefficient write strobe to the ExpandA polynomial memory.
REQ-012 coef_addr  output  8  coefficient index, 0..N_COEF-1.
REQ-013 coef_data  output  23  accepted coefficient.
REQ-014 busy  output  1  high from start until done.
REQ-015 done  output  1  one-cycle pulse after the last coefficient write.

Function
REQ-016 FSM states: IDLE, RUN, FLUSH, DONE; start in IDLE -> RUN; start in any other state is ignored.
REQ-017 Entering RUN clears the byte buffer, the coefficient counter and the block word counter.
REQ-018 The byte buffer holds up to 11 bytes (88 bits), filled little-endian; in_ready = 1 in RUN iff fill <= 3 bytes.
REQ-019 A 3-byte chunk b0,b1,b2 is extracted per cycle whenever fill >= 3; candidate = b0 | b1<<8 | (b2 & 0x7F)<<16.
REQ-020 An accepted word and a chunk extraction in the same cycle are both performed; fill updates by +8-3.
REQ-021 Candidate < Q: coef_we = 1, coef_data = candidate, coef_addr = counter, counter += 1, registered, one cycle after extraction.
REQ-022 Candidate >= Q: chunk discarded, no write, counter unchanged.
REQ-023 Latency: first write occurs no later than 2 cycles after the word completing its chunk is accepted.
REQ-024 Block word counter increments per accepted word; on the 21st word it wraps to 0 and squeeze_req pulses once in the same cycle, unless the polynomial is complete.
REQ-025 Because 168 is divisible by 3, no chunk straddles a block boundary; the buffer holds no partial chunk at wrap.
REQ-026 On the write with coef_addr = N_COEF-1: RUN -> FLUSH; in_ready = 0; remaining buffered bytes are discarded; no further writes.
REQ-027 FLUSH -> DONE after one cycle; DONE pulses done for one cycle, then -> IDLE.
REQ-028 busy = 1 in RUN, FLUSH and DONE; 0 in IDLE.
REQ-029 in_ready is 0 in IDLE, FLUSH and DONE; in_valid there is ignored.
REQ-030 coef_addr never exceeds N_COEF-1; coef_data is always < Q when coef_we = 1.

Reset
REQ-031 On rst: state = IDLE; in_ready, squeeze_req, coef_we, busy and done = 0; coef_addr = 0; coef_data = 0; buffer, fill and counters = 0.
REQ-032 Asserting rst mid-RUN aborts immediately with no further writes; after deassertion, start is required to begin again.

Configuration
REQ-033 Macro REJ_NTT_POLY_STATS_EN: when defined, add output rej_count (16 bits), counting rejected candidates since the last start and saturating at 0xFFFF, cleared by rst and by start; when undefined, the port and counter are absent and behaviour is otherwise identical.

Verification
REQ-034 Word with bytes 01 02 03 after start -> write addr 0, data 0x030201.
REQ-035 Chunk 00 E0 7F -> accepted, data 8380416 (Q-1); chunk 01 E0 7F -> rejected (= Q); chunk FF FF FF -> masked to 0x7FFFFF, rejected.
REQ-036 Stream 21 words all rejecting -> zero writes, exactly one squeeze_req on the 21st accepted word, counter still 0.
REQ-037 rho 0f2ebf0e...de da1f1c, nonce 0x0000 via SHAKE128 model -> 256 writes matching the golden ExpandA A[0][0], then done; in_ready = 0 afterwards.
REQ-038 Assert rst after 100 writes -> all outputs 0 the same cycle; new start restarts at coef_addr 0.
REQ-039 With REJ_NTT_POLY_STATS_EN: stimulus of REQ-035 -> rej_count = 2 after the three chunks.
